// File: rtl/axis_head_insert_verb.sv
// rtl/axis_head_insert_verb.sv - prepend a length-framed header from a side stream to every AXI-stream packet
//
// Purpose: for each packet, take `length` beats from the header stream and emit
// them first, then forward the payload packet unchanged.
// Optional feature macro: AXIS_HEAD_INSERT_CACHE_EN (2-entry registered output buffer).
//
// Ports:
//   aclk, areset                   clock, asynchronous active-high reset
//   length[15:0]                   header beat count, sampled in IDLE
//   head_tdata/tvalid/tlast/tready header source stream (tlast ignored)
//   axis_in_tdata/tvalid/tlast/tready  payload source stream
//   axis_out_tdata/tvalid/tlast/tready merged output stream

module axis_head_insert_verb #(
   parameter int DSIZE = 8
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic [15:0]      length,
   input  logic [DSIZE-1:0] head_tdata,
   input  logic             head_tvalid,
   input  logic             head_tlast,
   output logic             head_tready,
   input  logic [DSIZE-1:0] axis_in_tdata,
   input  logic             axis_in_tvalid,
   input  logic             axis_in_tlast,
   output logic             axis_in_tready,
   output logic [DSIZE-1:0] axis_out_tdata,
   output logic             axis_out_tvalid,
   output logic             axis_out_tlast,
   input  logic             axis_out_tready
);

   typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

   state_t           state;
   logic [15:0]      hcnt;
   logic [15:0]      len_lat;

   // merged stream before the optional output buffer
   logic [DSIZE-1:0] m_data;
   logic             m_valid;
   logic             m_last;
   logic             m_ready;

   // header framing comes from length only
   logic             unused_head_tlast;
   assign unused_head_tlast = head_tlast;

   // source select; IDLE drives nothing so no source is consumed in the bubble
   always_comb begin
      m_data         = '0;
      m_valid        = 1'b0;
      m_last         = 1'b0;
      head_tready    = 1'b0;
      axis_in_tready = 1'b0;
      case (state)
         HEAD: begin
            m_data      = head_tdata;
            m_valid     = head_tvalid;
            head_tready = m_ready;
         end
         BODY: begin
            m_data         = axis_in_tdata;
            m_valid        = axis_in_tvalid;
            m_last         = axis_in_tlast;
            axis_in_tready = m_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state   <= IDLE;
         hcnt    <= '0;
         len_lat <= '0;
      end else begin
         case (state)
            IDLE: begin
               len_lat <= length;
               hcnt    <= '0;
               state   <= (length != 16'd0) ? HEAD : BODY;
            end
            HEAD: begin
               if (head_tvalid && m_ready) begin
                  hcnt <= hcnt + 16'd1;
                  // len_lat is nonzero here, so len_lat-1 cannot wrap
                  if (hcnt == len_lat - 16'd1)
                     state <= BODY;
               end
            end
            BODY: begin
               if (axis_in_tvalid && m_ready && axis_in_tlast)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AXIS_HEAD_INSERT_CACHE_EN
   logic [DSIZE:0] buf_mem [2];
   logic           wr_ptr;
   logic           rd_ptr;
   logic [1:0]     count;
   logic [1:0]     count_nxt;
   logic           full;
   logic           push;
   logic           pop;

   // ready toward the FSM depends only on a flop, breaking the tready path
   assign m_ready   = ~full;
   assign push      = m_valid && m_ready;
   assign pop       = (count != 2'd0) && axis_out_tready;
   assign count_nxt = count + {1'b0, push} - {1'b0, pop};

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         full       <= 1'b0;
      end else begin
         if (push) begin
            buf_mem[wr_ptr] <= {m_last, m_data};
            wr_ptr          <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count_nxt;
         full  <= (count_nxt == 2'd2);
      end
   end

   assign axis_out_tvalid = (count != 2'd0);
   assign axis_out_tdata  = buf_mem[rd_ptr][DSIZE-1:0];
   assign axis_out_tlast  = buf_mem[rd_ptr][DSIZE];
`else
   assign m_ready         = axis_out_tready;
   assign axis_out_tvalid = m_valid;
   assign axis_out_tdata  = m_data;
   assign axis_out_tlast  = m_last;
`endif

endmodule

// File: tb/tb_axis_head_insert_verb.sv
// tb/tb_axis_head_insert_verb.sv - self-checking bench for axis_head_insert_verb
//
// Reference: expected output is the concatenation, per packet, of that packet's
// header beats followed by its payload beats. Sources obey AXI valid/hold rules.

module tb_axis_head_insert_verb;

   localparam int DSIZE = 8;
`ifdef AXIS_HEAD_INSERT_CACHE_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic             aclk = 1'b0;
   logic             areset = 1'b1;
   logic [15:0]      length = '0;
   logic [DSIZE-1:0] head_tdata = '0;
   logic             head_tvalid = 1'b0;
   logic             head_tlast = 1'b0;
   logic             head_tready;
   logic [DSIZE-1:0] axis_in_tdata = '0;
   logic             axis_in_tvalid = 1'b0;
   logic             axis_in_tlast = 1'b0;
   logic             axis_in_tready;
   logic [DSIZE-1:0] axis_out_tdata;
   logic             axis_out_tvalid;
   logic             axis_out_tlast;
   logic             axis_out_tready = 1'b0;

   always #5 aclk = ~aclk;

   axis_head_insert_verb #(.DSIZE(DSIZE)) dut (
      .aclk            (aclk),
      .areset          (areset),
      .length          (length),
      .head_tdata      (head_tdata),
      .head_tvalid     (head_tvalid),
      .head_tlast      (head_tlast),
      .head_tready     (head_tready),
      .axis_in_tdata   (axis_in_tdata),
      .axis_in_tvalid  (axis_in_tvalid),
      .axis_in_tlast   (axis_in_tlast),
      .axis_in_tready  (axis_in_tready),
      .axis_out_tdata  (axis_out_tdata),
      .axis_out_tvalid (axis_out_tvalid),
      .axis_out_tlast  (axis_out_tlast),
      .axis_out_tready (axis_out_tready)
   );

   int         errors = 0;
   int         checks = 0;
   logic [7:0] hsrc[$];
   logic [8:0] psrc[$];
   logic [8:0] exp_q[$];
   int         lens[$];
   int         cur_len, hcount, nstep, first_out, last_out;
   int         hprob, pprob, rmode, starve;
   bit         in_idle, hv, pv, prev_stall;
   logic [8:0] held;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic add_pkt(input int l, input int nb);
      logic [8:0] b;
      lens.push_back(l);
      for (int i = 0; i < l; i++) begin
         b = {1'b0, 8'($urandom)};
         hsrc.push_back(b[7:0]);
         exp_q.push_back(b);
      end
      for (int i = 0; i < nb; i++) begin
         b = {1'(i == nb - 1), 8'($urandom)};
         psrc.push_back(b);
         exp_q.push_back(b);
      end
   endtask

   // One clock: drive at negedge, sample 1 ns later, update model on transfers
   task automatic step();
      logic [8:0] e;
      @(negedge aclk);
      areset = 1'b0;
      nstep++;
      if (in_idle) begin
         cur_len = (lens.size() > 0) ? lens.pop_front() : 0;
         length  = 16'(cur_len);
      end else begin
         length = 16'($urandom);
      end
      if (starve > 0) starve--;
      else if (!hv && hsrc.size() > 0 && $urandom_range(99) < hprob) hv = 1'b1;
      if (!pv && psrc.size() > 0 && $urandom_range(99) < pprob) pv = 1'b1;
      head_tvalid    = hv;
      head_tdata     = hv ? hsrc[0] : 8'($urandom);
      head_tlast     = 1'($urandom);
      axis_in_tvalid = pv;
      axis_in_tdata  = pv ? psrc[0][7:0] : 8'($urandom);
      axis_in_tlast  = pv ? psrc[0][8] : 1'($urandom);
      case (rmode)
         0:       axis_out_tready = 1'b1;
         1:       axis_out_tready = 1'($urandom);
         default: axis_out_tready = (nstep % 3 == 1);
      endcase
      #1;
      if (in_idle) begin
         chk("idle_head_tready", head_tready, 0);
         chk("idle_in_tready", axis_in_tready, 0);
`ifndef AXIS_HEAD_INSERT_CACHE_EN
         chk("idle_out_tvalid", axis_out_tvalid, 0);
`endif
      end
      if (prev_stall) begin
         chk("stall_valid", axis_out_tvalid, 1);
         chk("stall_data_last", {axis_out_tlast, axis_out_tdata}, held);
      end
      if (axis_out_tvalid && axis_out_tready) begin
         chk("out_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_beat", {axis_out_tlast, axis_out_tdata}, e);
         end
         if (first_out < 0) first_out = nstep;
         last_out = nstep;
      end
      prev_stall = axis_out_tvalid && !axis_out_tready;
      held       = {axis_out_tlast, axis_out_tdata};
      if (head_tvalid && head_tready) begin
         void'(hsrc.pop_front());
         hv = 1'b0;
         hcount++;
      end
      in_idle = 1'b0;
      if (axis_in_tvalid && axis_in_tready) begin
         e  = psrc.pop_front();
         pv = 1'b0;
         if (e[8]) begin
            chk("head_beats_per_pkt", hcount, cur_len);
            hcount  = 0;
            in_idle = 1'b1;
         end
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || psrc.size() > 0) && n < budget) begin
         step();
         n++;
      end
      chk("drain_in_budget", 32'(n < budget), 1);
   endtask

   // Asserts reset, checks immediate reset values; the next step() releases it
   task automatic do_reset();
      @(negedge aclk);
      areset = 1'b1;
      head_tvalid = 1'b0;
      axis_in_tvalid = 1'b0;
      #1;
      chk("rst_head_tready", head_tready, 0);
      chk("rst_in_tready", axis_in_tready, 0);
      chk("rst_out_tvalid", axis_out_tvalid, 0);
      chk("rst_out_tlast", axis_out_tlast, 0);
      chk("rst_out_tdata", axis_out_tdata, 0);
      hsrc.delete(); psrc.delete(); exp_q.delete(); lens.delete();
      hv = 0; pv = 0; hcount = 0; in_idle = 1; prev_stall = 0;
      nstep = 0; first_out = -1; last_out = -1; starve = 0;
      @(negedge aclk);
   endtask

   initial begin
      hprob = 100; pprob = 100; rmode = 0;

      // basic insert: one bubble, then A0,A1,D0,D1,D2 back to back
      do_reset();
      add_pkt(2, 3);
      drain(50);
      chk("basic_first_out_cycle", first_out, 2 + LAT);
      chk("basic_last_out_cycle", last_out, 6 + LAT);

      // zero length with headers already waiting for the following packet
      do_reset();
      add_pkt(0, 2);
      add_pkt(3, 1);
      drain(50);

      // backpressure 1,0,0 pattern then random ready
      do_reset();
      rmode = 2;
      add_pkt(3, 4);
      drain(100);
      do_reset();
      rmode = 1;
      add_pkt(3, 4);
      add_pkt(2, 2);
      drain(100);

      // starved header: payload valid, header held off
      do_reset();
      rmode = 0;
      add_pkt(2, 2);
      starve = 6;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("starve_in_tready", axis_in_tready, 0);
         chk("starve_out_tvalid", axis_out_tvalid, 0);
      end
      drain(50);

      // back-to-back single-beat payloads, lengths 1,4,1
      do_reset();
      rmode = 1; hprob = 70; pprob = 70;
      add_pkt(1, 1);
      add_pkt(4, 1);
      add_pkt(1, 1);
      drain(200);

      // reset mid-header, then a clean packet
      do_reset();
      rmode = 0; hprob = 100; pprob = 100;
      add_pkt(4, 2);
      for (int i = 0; i < 20 && hcount < 1; i++) step();
      chk("a0_sent_before_reset", hcount, 1);
      do_reset();
      add_pkt(2, 2);
      drain(50);
      chk("post_reset_first_out", first_out, 2 + LAT);

      // randomized traffic with a long header
      do_reset();
      rmode = 1; hprob = 60; pprob = 60;
      for (int p = 0; p < 20; p++)
         add_pkt(($urandom_range(9) == 0) ? 40 : $urandom_range(5), $urandom_range(4, 1));
      add_pkt(300, 1);
      drain(5000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axis_head_insert_verb.md
# axis_head_insert_verb

Prepends a variable-length header to every AXI-stream packet: for each packet, `length` beats are taken from a dedicated header stream and emitted first, then the payload packet is forwarded unchanged. The block is the transmit-side counterpart of the variable-length head-cut stage, which strips the same header on receive. It sits between the header source and the payload source on one side and a downstream AXI-stream sink on the other, all on one clock.

## Interface
- `DSIZE`, default 8: data width in bits. Header, payload and output streams all use this width.
- `aclk` input 1: clock; all logic rising-edge.
- `areset` input 1: reset, asynchronous, active-high.
- `length` input 16: number of header beats for the next packet; sampled in IDLE.
- `head_tdata` input DSIZE: header beat data.
- `head_tvalid` input 1: header beat valid.
- `head_tlast` input 1: ignored; header framing comes from `length` only.
- `head_tready` output 1: header beat accepted.
- `axis_in_tdata` input DSIZE: payload data.
- `axis_in_tvalid` input 1: payload valid.
- `axis_in_tlast` input 1: payload end of packet.
- `axis_in_tready` output 1: payload accepted.
- `axis_out_tdata` output DSIZE: merged stream data.
- `axis_out_tvalid` output 1: merged stream valid.
- `axis_out_tlast` output 1: end of merged packet (payload tlast only).
- `axis_out_tready` input 1: downstream ready.

## Operation
- FSM states: IDLE, HEAD, BODY. Reset state IDLE.
- IDLE (one cycle, no transfers): latch `length` into `len_lat`, clear `hcnt`. Next state is HEAD if `length != 0`, otherwise BODY.
- HEAD:
  - Output is driven from the header stream: data = `head_tdata`, valid = `head_tvalid`, tlast = 0.
  - `head_tready` follows output-side ready; `axis_in_tready` = 0.
  - `hcnt` increments on each header transfer. The transfer with `hcnt == len_lat-1` moves to BODY.
- BODY:
  - Output is driven from the payload: data/valid/tlast = `axis_in_*`.
  - `axis_in_tready` follows output-side ready; `head_tready` = 0.
  - The transfer with `axis_in_tlast=1` moves to IDLE.
- Arithmetic: `hcnt` and `len_lat` are 16 bits, unsigned. `length = 16'hFFFF` gives 65535 header beats with no wrap.
- `length` changes outside IDLE are ignored for the current packet.
- Header beats beyond `len_lat` stay in the header stream and are used by the next packet. A header stream that is starved stalls output with valid low.
- A payload with a single beat (tlast on the first beat) is legal. A zero-length payload does not exist.
- A transfer is `tvalid && tready` on the same edge. No source is consumed without an output-side acceptance.

## Timing
- Reset values: `head_tready=0`, `axis_in_tready=0`, `axis_out_tvalid=0`, `axis_out_tlast=0`, `axis_out_tdata=0`. FSM=IDLE, `hcnt=0`, `len_lat=0`, buffer empty.
- Reset asserted mid-packet: immediate return to the reset values. Partially sent header and payload beats are dropped by this block; upstream re-framing is the sender's responsibility.
- Per-packet overhead: exactly one IDLE bubble cycle. Within HEAD and BODY, throughput is one beat per cycle.
- Switching HEAD→BODY and BODY→IDLE happens on the clock edge of the qualifying transfer. No gap between the last header beat and the first payload beat.
- A stalled output (`axis_out_tready=0`) holds data and tlast stable while valid is high, per AXI-stream rules.

## Configuration
- `AXIS_HEAD_INSERT_CACHE_EN` defined:
  - The merged stream passes through a 2-entry registered skid buffer before `axis_out_*`.
  - Output-side ready seen by the FSM = buffer not full (registered).
  - First-beat latency is 1 cycle after the source transfer; full throughput is preserved.
  - `axis_out_*` are driven by flops, so there is no combinational path from `axis_out_tready` to any input-side ready.
- Not defined:
  - `axis_out_*` are combinational muxes of the selected source, with 0-cycle latency.
  - Output-side ready = `axis_out_tready`, so a combinational ready path exists.

## Test plan
- Basic insert: `length=2`, header A0,A1, payload D0,D1,D2(tlast), sink always ready -> output A0,A1,D0,D1,D2. tlast only on D2; exactly 1 idle cycle before A0.
- Zero length: `length=0`, payload D0,D1(tlast) -> output D0,D1(tlast). `head_tready` never asserts; header FIFO contents are untouched.
- Backpressure: `length=3`, sink ready toggles 1,0,0,1,… -> output order and data unchanged. Data/tlast stable while valid and not ready; no beat lost or duplicated. Run both with and without `AXIS_HEAD_INSERT_CACHE_EN`.
- Starved header: `length=2`, header arrives 5 cycles after payload is valid -> `axis_out_tvalid=0` and `axis_in_tready=0` until A0 arrives, then A0,A1,payload.
- Back-to-back packets: `length` alternates 1 and 4, with 3 single-beat payloads -> 1,4,1 header beats respectively, each followed by its payload. `length` changes mid-packet have no effect.
- Reset mid-header: assert `areset` after A0 of a `length=4` packet -> all outputs at reset values immediately. After release, the next packet frames correctly from IDLE.
